// File: rtl/scale_frame_ctrl.sv
// Frame sequencer for the scaler pipeline: owns the shadow/active scale config,
// counts output pixels into rows/columns and issues the DDR3 write per pixel.
//
// state | meaning
// IDLE  | waiting for a source frame start; pixels dropped with frame_err
// LOAD  | one cycle: shadow -> active (clamped), counters and base reset
// RUN   | writing pixels, advancing col/row/addr
// DONE  | one cycle: frame complete, frame_done follows
module scale_frame_ctrl #(
    parameter int FIX_LEN     = 15,
    parameter int PIX_WIDTH   = 16,
    parameter int LINE_STRIDE = 640,
    parameter int MAX_V       = 360,
    parameter int ADDR_W      = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FIX_LEN-1:0]   cfg_x_scale,
    input  logic [FIX_LEN-1:0]   cfg_y_scale,
    input  logic [12:0]          cfg_h_num,
    input  logic [12:0]          cfg_v_num,
    input  logic                 cfg_wr,
    input  logic                 vsync_in,
    input  logic [PIX_WIDTH-1:0] pix_data_in,
    input  logic                 pix_vaild_in,
    output logic [FIX_LEN-1:0]   x_scale,
    output logic [FIX_LEN-1:0]   y_scale,
    output logic [12:0]          TARGET_H_NUM,
    output logic [12:0]          TARGET_V_NUM,
    output logic                 wr_en,
    output logic [PIX_WIDTH-1:0] wr_data,
    output logic [ADDR_W-1:0]    DDR3_ADDR,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic                 frame_err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [FIX_LEN-1:0] SCALE_RST = FIX_LEN'(256);
    localparam logic [12:0]        STRIDE_N  = 13'(LINE_STRIDE);
    localparam logic [12:0]        MAXV_N    = 13'(MAX_V);
    localparam logic [ADDR_W-1:0]  STRIDE_A  = ADDR_W'(LINE_STRIDE);

    state_t               state_q, state_d;
    logic [FIX_LEN-1:0]   sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic [12:0]          sh_h_q, sh_h_d, sh_v_q, sh_v_d;
    logic [FIX_LEN-1:0]   act_x_q, act_x_d, act_y_q, act_y_d;
    logic [12:0]          act_h_q, act_h_d, act_v_q, act_v_d;
    logic [12:0]          col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0]    row_base_q, row_base_d, addr_q, addr_d;
    logic                 wr_en_q, wr_en_d;
    logic [PIX_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [FIX_LEN-1:0]   ld_x, ld_y;
    logic [12:0]          ld_h, ld_v;
    logic [ADDR_W-1:0]    ld_base;
    logic                 accept;

    function automatic logic [12:0] clamp_num(input logic [12:0] n, input logic [12:0] lim);
        if (n == 13'd0) return 13'd1;
        if (n > lim) return lim;
        return n;
    endfunction

    always_comb begin
        state_d    = state_q;
        sh_x_d     = sh_x_q;
        sh_y_d     = sh_y_q;
        sh_h_d     = sh_h_q;
        sh_v_d     = sh_v_q;
        act_x_d    = act_x_q;
        act_y_d    = act_y_q;
        act_h_d    = act_h_q;
        act_v_d    = act_v_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;

        // A cfg_wr coinciding with LOAD is taken by that LOAD directly.
        ld_x    = cfg_wr ? cfg_x_scale : sh_x_q;
        ld_y    = cfg_wr ? cfg_y_scale : sh_y_q;
        ld_h    = clamp_num(cfg_wr ? cfg_h_num : sh_h_q, STRIDE_N);
        ld_v    = clamp_num(cfg_wr ? cfg_v_num : sh_v_q, MAXV_N);
        ld_base = STRIDE_A * ADDR_W'(MAXV_N - ld_v);

        accept    = (state_q == S_RUN) && pix_vaild_in;
        wr_en_d   = accept;
        wr_data_d = accept ? pix_data_in : wr_data_q;
        wr_addr_d = accept ? addr_q : wr_addr_q;
        err_d     = pix_vaild_in && (state_q != S_RUN);
        done_d    = (state_q == S_DONE);

        if (cfg_wr) begin
            sh_x_d = cfg_x_scale;
            sh_y_d = cfg_y_scale;
            sh_h_d = cfg_h_num;
            sh_v_d = cfg_v_num;
        end

        case (state_q)
            S_IDLE: begin
                if (vsync_in) state_d = S_LOAD;
            end
            S_LOAD: begin
                act_x_d    = ld_x;
                act_y_d    = ld_y;
                act_h_d    = ld_h;
                act_v_d    = ld_v;
                col_d      = 13'd0;
                row_d      = 13'd0;
                row_base_d = ld_base;
                addr_d     = ld_base;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (accept) begin
                    if ((col_q + 13'd1) < act_h_q) begin
                        col_d  = col_q + 13'd1;
                        addr_d = addr_q + ADDR_W'(1);
                    end else begin
                        col_d      = 13'd0;
                        row_d      = row_q + 13'd1;
                        row_base_d = row_base_q + STRIDE_A;
                        addr_d     = row_base_q + STRIDE_A;
                        if ((row_q + 13'd1) == act_v_q) state_d = S_DONE;
                    end
                end
                // Early restart wins over frame completion.
                if (vsync_in) begin
                    state_d = S_LOAD;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sh_x_q     <= SCALE_RST;
            sh_y_q     <= SCALE_RST;
            sh_h_q     <= STRIDE_N;
            sh_v_q     <= MAXV_N;
            act_x_q    <= SCALE_RST;
            act_y_q    <= SCALE_RST;
            act_h_q    <= STRIDE_N;
            act_v_q    <= MAXV_N;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_x_q     <= sh_x_d;
            sh_y_q     <= sh_y_d;
            sh_h_q     <= sh_h_d;
            sh_v_q     <= sh_v_d;
            act_x_q    <= act_x_d;
            act_y_q    <= act_y_d;
            act_h_q    <= act_h_d;
            act_v_q    <= act_v_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            wr_addr_q  <= wr_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign x_scale      = act_x_q;
    assign y_scale      = act_y_q;
    assign TARGET_H_NUM = act_h_q;
    assign TARGET_V_NUM = act_v_q;
    assign wr_en        = wr_en_q;
    assign wr_data      = wr_data_q;
    assign DDR3_ADDR    = wr_addr_q;
    assign frame_busy   = busy_q;
    assign frame_done   = done_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_scale_frame_ctrl.sv
// Bench for scale_frame_ctrl: a frame-level model predicts every output each
// cycle; literal addresses at frame corners pin the model.
module tb_scale_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] cfg_x_scale = '0, cfg_y_scale = '0;
    logic [12:0] cfg_h_num = '0, cfg_v_num = '0;
    logic        cfg_wr = 1'b0, vsync_in = 1'b0, pix_vaild_in = 1'b0;
    logic [15:0] pix_data_in = '0;
    logic [14:0] x_scale, y_scale;
    logic [12:0] TARGET_H_NUM, TARGET_V_NUM;
    logic        wr_en, frame_busy, frame_done, frame_err;
    logic [15:0] wr_data;
    logic [27:0] DDR3_ADDR;

    scale_frame_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_x_scale(cfg_x_scale), .cfg_y_scale(cfg_y_scale),
        .cfg_h_num(cfg_h_num), .cfg_v_num(cfg_v_num), .cfg_wr(cfg_wr),
        .vsync_in(vsync_in), .pix_data_in(pix_data_in), .pix_vaild_in(pix_vaild_in),
        .x_scale(x_scale), .y_scale(y_scale),
        .TARGET_H_NUM(TARGET_H_NUM), .TARGET_V_NUM(TARGET_V_NUM),
        .wr_en(wr_en), .wr_data(wr_data), .DDR3_ADDR(DDR3_ADDR),
        .frame_busy(frame_busy), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: mode 0 idle, 1 load, 2 run, 3 done.
    int m_mode, sh_x, sh_y, sh_h, sh_v, ac_x, ac_y, ac_h, ac_v, m_col, m_row;
    int lx, ly, lh, lv;
    bit e_wr, e_done, e_err, e_busy;
    int e_data, e_addr;

    function automatic int clampn(input int n, input int lim);
        if (n == 0) return 1;
        if (n > lim) return lim;
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0;
            sh_x = 256; sh_y = 256; sh_h = 640; sh_v = 360;
            ac_x = 256; ac_y = 256; ac_h = 640; ac_v = 360;
            m_col = 0; m_row = 0;
            e_wr = 0; e_done = 0; e_err = 0; e_busy = 0; e_data = 0; e_addr = 0;
        end else begin
            lx = cfg_wr ? int'(cfg_x_scale) : sh_x;
            ly = cfg_wr ? int'(cfg_y_scale) : sh_y;
            lh = cfg_wr ? int'(cfg_h_num) : sh_h;
            lv = cfg_wr ? int'(cfg_v_num) : sh_v;
            if (cfg_wr) begin
                sh_x = lx; sh_y = ly; sh_h = lh; sh_v = lv;
            end
            e_wr = 0;
            e_err = 0;
            e_done = (m_mode == 3);
            case (m_mode)
                0: begin
                    if (pix_vaild_in) e_err = 1;
                    if (vsync_in) m_mode = 1;
                end
                1: begin
                    if (pix_vaild_in) e_err = 1;
                    ac_x = lx; ac_y = ly;
                    ac_h = clampn(lh, 640); ac_v = clampn(lv, 360);
                    m_col = 0; m_row = 0;
                    m_mode = 2;
                end
                2: begin
                    if (pix_vaild_in) begin
                        e_wr = 1;
                        e_data = int'(pix_data_in);
                        e_addr = 640 * (360 - ac_v) + 640 * m_row + m_col;
                        m_col++;
                        if (m_col == ac_h) begin
                            m_col = 0;
                            m_row++;
                            if (m_row == ac_v) m_mode = 3;
                        end
                    end
                    if (vsync_in) begin
                        e_err = 1;
                        m_mode = 1;
                    end
                end
                default: begin
                    if (pix_vaild_in) e_err = 1;
                    m_mode = 0;
                end
            endcase
            e_busy = (m_mode == 1) || (m_mode == 2);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_en", wr_en, e_wr);
            check("frame_busy", frame_busy, e_busy);
            check("frame_done", frame_done, e_done);
            check("frame_err", frame_err, e_err);
            check("x_scale", x_scale, ac_x);
            check("y_scale", y_scale, ac_y);
            check("target_h", TARGET_H_NUM, ac_h);
            check("target_v", TARGET_V_NUM, ac_v);
            if (e_wr) begin
                check("wr_data", wr_data, e_data);
                check("ddr3_addr", DDR3_ADDR, e_addr);
            end
        end
    end

    task automatic cyc(input bit pv, input bit vs, input int d);
        pix_vaild_in = pv;
        vsync_in     = vs;
        pix_data_in  = 16'(d);
        @(negedge clk);
        pix_vaild_in = 1'b0;
        vsync_in     = 1'b0;
    endtask

    task automatic set_cfg(input int x, input int y, input int h, input int v);
        cfg_x_scale = 15'(x); cfg_y_scale = 15'(y);
        cfg_h_num = 13'(h); cfg_v_num = 13'(v);
        cfg_wr = 1'b1;
        cyc(0, 0, 0);
        cfg_wr = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!frame_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_wait", frame_done, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_x_scale", x_scale, 256);
        check("rst_h", TARGET_H_NUM, 640);
        check("rst_v", TARGET_V_NUM, 360);
        check("rst_addr", DDR3_ADDR, 0);
        rst = 1'b0;

        // Pixel in IDLE, then vsync and a pixel in the LOAD cycle.
        cyc(1, 0, 7);
        check("idle_drop_err", frame_err, 1);
        check("idle_drop_wr", wr_en, 0);
        cyc(0, 1, 0);
        cyc(1, 0, 9);
        check("load_drop_err", frame_err, 1);
        check("load_drop_wr", wr_en, 0);
        check("load_busy", frame_busy, 1);

        // Default frame; new config arrives mid-frame and must not apply yet.
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                cfg_x_scale = 15'h0080; cfg_y_scale = 15'h0080;
                cfg_h_num = 13'd320; cfg_v_num = 13'd180;
                cfg_wr = 1'b1;
            end
            cyc(1, 0, i + 100);
            cfg_wr = 1'b0;
            if (i == 0) check("first_addr_default", DDR3_ADDR, 0);
        end
        check("addr_999", DDR3_ADDR, 999);
        check("h_held_midframe", TARGET_H_NUM, 640);

        // Early vsync with a coincident pixel.
        cyc(1, 1, 5000);
        check("early_pix_wr", wr_en, 1);
        check("early_pix_addr", DDR3_ADDR, 1000);
        check("early_err", frame_err, 1);
        cyc(0, 0, 0);
        check("new_h", TARGET_H_NUM, 320);
        check("new_v", TARGET_V_NUM, 180);
        for (int i = 0; i < 330; i++) begin
            cyc(1, 0, i);
            if (i == 0) begin
                check("base_320x180", DDR3_ADDR, 115200);
                check("model_base_320x180", e_addr, 115200);
            end
            if (i == 320) check("line1_320x180", DDR3_ADDR, 115840);
        end

        // Full-width two-line frame reaching the last DDR3 pixel.
        set_cfg(256, 256, 640, 2);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 1280; i++) begin
            cyc(1, 0, i * 3);
            if (i == 0) check("base_640x2", DDR3_ADDR, 229120);
        end
        check("last_addr", DDR3_ADDR, 230399);
        check("model_last_addr", e_addr, 230399);
        check("done_not_yet", frame_done, 0);
        cyc(0, 0, 0);
        check("done_after_last", frame_done, 1);
        cyc(0, 0, 0);
        check("done_one_cycle", frame_done, 0);

        // Zero size clamps to 1x1.
        set_cfg(256, 256, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        check("clamp_h1", TARGET_H_NUM, 1);
        check("clamp_v1", TARGET_V_NUM, 1);
        cyc(1, 0, 16'h1234);
        check("base_1x1", DDR3_ADDR, 229760);
        check("wr_1x1", wr_en, 1);
        wait_done(4);

        // Config written in the LOAD cycle itself.
        cyc(0, 1, 0);
        cfg_x_scale = 15'h0200; cfg_y_scale = 15'h0300;
        cfg_h_num = 13'd5; cfg_v_num = 13'd3;
        cfg_wr = 1'b1;
        cyc(0, 0, 0);
        cfg_wr = 1'b0;
        check("load_cfg_h", TARGET_H_NUM, 5);
        check("load_cfg_x", x_scale, 15'h0200);
        for (int i = 0; i < 15; i++) cyc(1, 0, i + 40);
        check("last_5x3", DDR3_ADDR, 229764);
        wait_done(4);

        // Oversize clamps to the frame area.
        set_cfg(15'h0300, 15'h0300, 1000, 500);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        check("clamp_h_max", TARGET_H_NUM, 640);
        check("clamp_v_max", TARGET_V_NUM, 360);

        // Reset mid-row with a pixel in flight.
        for (int i = 0; i < 10; i++) cyc(1, 0, i);
        rst = 1'b1;
        cyc(1, 0, 77);
        cyc(0, 0, 0);
        check("mid_rst_wr", wr_en, 0);
        check("mid_rst_busy", frame_busy, 0);
        check("mid_rst_x", x_scale, 256);
        rst = 1'b0;
        cyc(1, 0, 1);
        check("post_rst_wr", wr_en, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 2);
        check("post_rst_base", DDR3_ADDR, 0);
        cyc(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
